mem_request_master: RTL

Initiator side of the data-memory port used by the memory stage. Accepts one load/store request at a time from the pipeline over a valid/ready handshake. Range-checks the address against the data-memory window and drives mem_read/mem_write, mem_address and mem_write_data toward the memory. It waits on mem_ready, bounded by a timeout, and returns exactly one response pulse per accepted request with read data or an error flag.

---
 rtl/mem_request_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_request_master.sv
// mem_request_master: one-at-a-time load/store initiator for the data-memory port.
// Range-checks the word-aligned address and drives a read or write strobe
// until the memory signals ready or the wait budget runs out. Exactly one
// response pulse is returned per accepted request.
module mem_request_master #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int          MEM_BYTES = 512,
    parameter logic [15:0] TIMEOUT   = 16'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic        o_busy,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    input  logic [31:0] i_mem_read_data,
    input  logic        i_mem_ready
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    // Window limits widened to 33 bits so base + size can never wrap.
    localparam logic [32:0] LO_ADDR = {1'b0, ADDR_BASE};
    localparam logic [32:0] HI_ADDR = {1'b0, ADDR_BASE} + 33'(MEM_BYTES) - 33'd4;

    state_t      r_state, w_state_next;
    logic [31:0] r_addr, w_addr_next;
    logic [31:0] r_wdata, w_wdata_next;
    logic [15:0] r_wait, w_wait_next;
    logic        r_err, w_err_next;
    logic [31:0] r_rdata, w_rdata_next;

    logic [31:0] w_aligned;
    logic        w_in_range;
    logic [15:0] w_wait_inc;
    logic        w_timeout;

    assign w_aligned  = i_req_addr & ~32'h3;
    assign w_in_range = ({1'b0, w_aligned} >= LO_ADDR) && ({1'b0, w_aligned} <= HI_ADDR);
    // Saturate so a disabled timeout never lets the counter wrap.
    assign w_wait_inc = (r_wait == 16'hFFFF) ? r_wait : r_wait + 16'd1;
    assign w_timeout  = (TIMEOUT != 16'd0) && (w_wait_inc == TIMEOUT);

    // Strobes and handshake flags are pure state decodes.
    assign o_req_ready      = (r_state == IDLE);
    assign o_busy           = (r_state != IDLE);
    assign o_mem_read       = (r_state == RD);
    assign o_mem_write      = (r_state == WR);
    assign o_resp_valid     = (r_state == RESP);
    assign o_mem_address    = r_addr;
    assign o_mem_write_data = r_wdata;
    assign o_resp_err       = r_err;
    assign o_resp_rdata     = r_rdata;

    // Register all state; reset drops strobes immediately and forgets any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wait  <= 16'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_wait  <= w_wait_next;
            r_err   <= w_err_next;
            r_rdata <= w_rdata_next;
        end
    end

    // Next-state and datapath decisions; everything holds unless updated.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_wait_next  = r_wait;
        w_err_next   = r_err;
        w_rdata_next = r_rdata;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_addr_next  = w_aligned;
                    w_wdata_next = i_req_wdata;
                    w_wait_next  = 16'd0;
                    if (w_in_range) begin
                        w_state_next = i_req_write ? WR : RD;
                    end else begin
                        // Out-of-window requests never touch the memory.
                        w_state_next = RESP;
                        w_err_next   = 1'b1;
                        w_rdata_next = 32'd0;
                    end
                end
            end
            RD: begin
                if (i_mem_ready) begin
                    w_state_next = RESP;
                    w_err_next   = 1'b0;
                    w_rdata_next = i_mem_read_data;
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_timeout) begin
                        w_state_next = RESP;
                        w_err_next   = 1'b1;
                        w_rdata_next = 32'd0;
                    end
                end
            end
            WR: begin
                // Stores leave the read-data register untouched.
                if (i_mem_ready) begin
                    w_state_next = RESP;
                    w_err_next   = 1'b0;
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_timeout) begin
                        w_state_next = RESP;
                        w_err_next   = 1'b1;
                    end
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
